// File: rtl/fifo9_tx_arbiter.sv
// Two-source 9-bit frame arbiter feeding a GMII transmit FIFO, with round-robin grant and MAX_LEN truncation.
// Optional inter-frame gap insertion is built when the TXARB_IFG_EN macro is defined.
module fifo9_tx_arbiter #(
  parameter int IFG_WORDS = 12,
  parameter int MAX_LEN   = 1522
) (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst,
  input  logic [8:0] src0_dout,
  input  logic       src0_empty,
  output logic       src0_rd_en,
  input  logic [8:0] src1_dout,
  input  logic       src1_empty,
  output logic       src1_rd_en,
  output logic [8:0] din,
  output logic       wr_en,
  input  logic       full,
  output logic [1:0] grant,
  output logic       err_len
);

`ifdef TXARB_IFG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DROP = 2'd2, GAP = 2'd3} state_t;
  localparam state_t END_ST = GAP;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DROP = 2'd2} state_t;
  localparam state_t END_ST = IDLE;
`endif

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [11:0] len_q, len_d;
  logic        err_q, err_d;
`ifdef TXARB_IFG_EN
  logic [15:0] gap_q, gap_d;
`endif

  logic       rd0, rd1, wr;
  logic [8:0] din_o;
  logic       req0, req1;
  logic [8:0] own_dout;
  logic       own_empty;

  assign req0      = !src0_empty && src0_dout[8];
  assign req1      = !src1_empty && src1_dout[8];
  assign own_dout  = grant_q[1] ? src1_dout : src0_dout;
  assign own_empty = grant_q[1] ? src1_empty : src0_empty;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    err_d   = 1'b0;
`ifdef TXARB_IFG_EN
    gap_d   = gap_q;
`endif
    rd0     = 1'b0;
    rd1     = 1'b0;
    wr      = 1'b0;
    din_o   = 9'h000;
    case (state_q)
      IDLE: begin
        // Stray end markers at the head are flushed so they never start a frame.
        rd0 = !src0_empty && !src0_dout[8];
        rd1 = !src1_empty && !src1_dout[8];
        if (req0 && (!req1 || last_q)) begin
          grant_d = 2'b01;
          state_d = SEND;
          len_d   = '0;
        end else if (req1) begin
          grant_d = 2'b10;
          state_d = SEND;
          len_d   = '0;
        end
      end
      SEND: begin
        if (!own_empty && !full) begin
          wr = 1'b1;
          if (own_dout[8] && len_q == 12'(MAX_LEN)) begin
            // Terminate downstream early; the rest of the source frame is drained in DROP.
            err_d   = 1'b1;
            state_d = DROP;
          end else begin
            din_o = own_dout;
            rd0   = !grant_q[1];
            rd1   = grant_q[1];
            if (own_dout[8]) begin
              len_d = len_q + 12'd1;
            end else begin
              state_d = END_ST;
              grant_d = 2'b00;
              last_d  = grant_q[1];
            end
          end
        end
      end
      DROP: begin
        if (!own_empty) begin
          rd0 = !grant_q[1];
          rd1 = grant_q[1];
          if (!own_dout[8]) begin
            state_d = END_ST;
            grant_d = 2'b00;
            last_d  = grant_q[1];
          end
        end
      end
`ifdef TXARB_IFG_EN
      GAP: begin
        if (!full) begin
          wr = 1'b1;
          if (gap_q == 16'(IFG_WORDS - 1)) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Strobes are combinational, so they must be masked while the state is still pre-reset.
    if (sys_rst) begin
      rd0   = 1'b0;
      rd1   = 1'b0;
      wr    = 1'b0;
      din_o = 9'h000;
    end
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      len_q   <= '0;
      err_q   <= 1'b0;
`ifdef TXARB_IFG_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      err_q   <= err_d;
`ifdef TXARB_IFG_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign src0_rd_en = rd0;
  assign src1_rd_en = rd1;
  assign wr_en      = wr;
  assign din        = din_o;
  assign grant      = grant_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_fifo9_tx_arbiter.sv
// Scoreboard bench for fifo9_tx_arbiter: queue-backed FWFT sources, a frame-level reference model
// and a decoupled monitor checking every downstream write, err_len timing and strobe rules.
module tb_fifo9_tx_arbiter;
  localparam int IFG  = 12;
  localparam int MAXL = 64;
`ifdef TXARB_IFG_EN
  localparam int GAPW = IFG;
`else
  localparam int GAPW = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] s0d = 9'h000, s1d = 9'h000, din;
  logic       s0e = 1'b1, s1e = 1'b1, rd0, rd1, wr, err;
  logic       full = 1'b0;
  logic [1:0] grant;

  always #5 clk = ~clk;

  fifo9_tx_arbiter #(.IFG_WORDS(IFG), .MAX_LEN(MAXL)) dut (
    .gmii_tx_clk(clk), .sys_rst(rst),
    .src0_dout(s0d), .src0_empty(s0e), .src0_rd_en(rd0),
    .src1_dout(s1d), .src1_empty(s1e), .src1_rd_en(rd1),
    .din(din), .wr_en(wr), .full(full), .grant(grant), .err_len(err)
  );

  typedef struct packed {logic [8:0] w; logic [1:0] g; logic tr;} exp_t;
  exp_t       expq[$];
  logic [8:0] q0[$], q1[$];
  int  tests = 0, fails = 0;
  int  model_last = 1;
  int  pops0 = 0, pops1 = 0, done0 = 0, done1 = 0, wr_cnt = 0;
  bit  toggle_full = 0, rand_full = 0, rand_hide = 0, in_rst = 0, err_pend = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Source FIFOs and downstream full: pops recorded by the monitor take effect after the clock edge.
  always @(negedge clk) begin
    while (done0 < pops0) begin if (q0.size() > 0) q0.delete(0); done0++; end
    while (done1 < pops1) begin if (q1.size() > 0) q1.delete(0); done1++; end
    if (toggle_full) full = ~full;
    else full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    s0e = (q0.size() == 0) || (rand_hide && grant == 2'b01 && $urandom_range(0, 3) == 0);
    s1e = (q1.size() == 0) || (rand_hide && grant == 2'b10 && $urandom_range(0, 3) == 0);
    s0d = (q0.size() > 0) ? q0[0] : 9'h000;
    s1d = (q1.size() > 0) ? q1[0] : 9'h000;
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (in_rst) begin
        chk("rst_rd0", rd0, 0);
        chk("rst_rd1", rd1, 0);
        chk("rst_wr", wr, 0);
        chk("rst_din", din, 0);
      end
    end else begin
      chk("wr_while_full", wr & full, 0);
      chk("rd_while_empty", (rd0 & s0e) | (rd1 & s1e), 0);
      chk("nonowner_pop", (grant == 2'b01 && rd1) || (grant == 2'b10 && rd0), 0);
      chk("grant_onehot", grant == 2'b11, 0);
      if (err || err_pend) chk("err_len", err, err_pend);
      err_pend = 0;
      if (wr) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_wr actual=%0h required=none", din);
        end else begin
          mon_e = expq.pop_front();
          chk("din", din, mon_e.w);
          chk("grant", grant, mon_e.g);
          if (mon_e.tr) err_pend = 1;
        end
        wr_cnt++;
      end
      if (rd0) pops0++;
      if (rd1) pops1++;
    end
  end

  // Reference: split each source into frames, serve them round robin, truncate beyond MAXL.
  task automatic build_expect();
    logic [8:0] a0[$], a1[$], w;
    int s, n;
    logic [1:0] g;
    a0 = q0;
    a1 = q1;
    while (a0.size() > 0 || a1.size() > 0) begin
      if (a0.size() > 0 && a1.size() > 0) s = 1 - model_last;
      else s = (a0.size() > 0) ? 0 : 1;
      g = (s == 0) ? 2'b01 : 2'b10;
      n = 0;
      forever begin
        w = (s == 0) ? a0.pop_front() : a1.pop_front();
        if (!w[8]) break;
        if (n < MAXL) expq.push_back('{w: w, g: g, tr: 1'b0});
        n++;
      end
      expq.push_back('{w: 9'h000, g: g, tr: (n > MAXL)});
      for (int i = 0; i < GAPW; i++) expq.push_back('{w: 9'h000, g: 2'b00, tr: 1'b0});
      model_last = s;
    end
  endtask

  task automatic push_frame(input int src, input int len);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w = {1'b1, 8'($urandom)};
      if (src == 0) q0.push_back(w); else q1.push_back(w);
    end
    if (src == 0) q0.push_back(9'h000); else q1.push_back(9'h000);
  endtask

  task automatic wait_done(input string name);
    int c;
    for (c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (expq.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
    end
    if (c == 20000) begin
      tests++; fails++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, expq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    q0.delete(); q1.delete(); expq.delete();
    model_last = 1;
    rst = 0;
  endtask

  int base;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #3;
    chk("reset_grant", grant, 2'b00);
    chk("reset_err", err, 0);
    chk("reset_wr", wr, 0);
    chk("reset_din", din, 9'h000);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // single frame
    base = wr_cnt;
    push_frame(0, 60); build_expect(); wait_done("single");
    chk("single_writes", wr_cnt - base, 61 + GAPW);

    // contention right after reset: 0,1,0,1
    apply_reset();
    @(posedge clk); #1;
    base = wr_cnt;
    push_frame(0, 64); push_frame(0, 64); push_frame(1, 64); push_frame(1, 64);
    build_expect(); wait_done("contention");
    chk("contention_writes", wr_cnt - base, 4 * (65 + GAPW));

    // backpressure
    toggle_full = 1;
    base = wr_cnt;
    push_frame(0, 100); build_expect(); wait_done("backpressure");
    chk("bp_writes", wr_cnt - base, MAXL + 1 + GAPW);
    toggle_full = 0;

    // truncation on source 1
    base = wr_cnt;
    push_frame(1, 80); build_expect(); wait_done("trunc");
    chk("trunc_writes", wr_cnt - base, MAXL + 1 + GAPW);

    // stray marker
    base = wr_cnt;
    q0.push_back(9'h0AB);
    repeat (6) @(posedge clk); #1;
    chk("stray_popped", q0.size(), 0);
    chk("stray_no_write", wr_cnt - base, 0);

    // randomized traffic
    rand_full = 1; rand_hide = 1;
    for (int r = 0; r < 20; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int k = 0; k < n0; k++) push_frame(0, ($urandom_range(0, 4) == 0) ? 64 + $urandom_range(0, 1) : $urandom_range(1, 90));
      for (int k = 0; k < n1; k++) push_frame(1, ($urandom_range(0, 4) == 0) ? 64 + $urandom_range(0, 1) : $urandom_range(1, 90));
      build_expect();
      wait_done("random");
    end
    rand_full = 0; rand_hide = 0;

    // reset in the middle of a frame
    base = wr_cnt;
    push_frame(0, 40); build_expect();
    for (int c = 0; c < 200 && wr_cnt - base < 10; c++) begin @(posedge clk); #1; end
    chk("midframe_progress", (wr_cnt - base) >= 10, 1);
    in_rst = 1; rst = 1;
    @(posedge clk); #1;
    q0.delete(); q1.delete(); expq.delete();
    model_last = 1;
    in_rst = 0; rst = 0;
    @(negedge clk); #3;
    chk("post_rst_grant", grant, 2'b00);
    chk("post_rst_strobes", {rd0, rd1, wr}, 3'b000);
    @(posedge clk); #1;
    base = wr_cnt;
    push_frame(1, 20); push_frame(0, 30); build_expect(); wait_done("post_rst_tie");
    chk("post_rst_writes", wr_cnt - base, 21 + 31 + 2 * GAPW);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo9_tx_arbiter.md
FIFO9_TX_ARBITER -- requirements
Module: fifo9_tx_arbiter

Interface
REQ-001 Parameter IFG_WORDS, default 12: number of 9'h000 gap words written after each frame.
REQ-002 Parameter MAX_LEN, default 1522: maximum data words (bit 8 = 1) forwarded per frame.
REQ-003 gmii_tx_clk  in  1  single clock; all logic rises on posedge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 src0_dout  in  9  source 0 FWFT FIFO head; bit 8 = 1 frame byte, bit 8 = 0 end-of-frame marker.
REQ-006 src0_empty  in  1  source 0 FIFO empty.
REQ-007 src0_rd_en  out  1  source 0 pop strobe.
REQ-008 src1_dout / src1_empty / src1_rd_en  in/in/out  9/1/1  source 1; same meaning as source 0.
REQ-009 din  out  9  write data to the downstream FIFO that feeds the GMII transmitter.
REQ-010 wr_en  out  1  downstream FIFO write strobe.
REQ-011 full  in  1  downstream FIFO full.
REQ-012 grant  out  2  one-hot registered owner of the current frame; 2'b00 when no frame is owned.
REQ-013 err_len  out  1  one-cycle pulse when a frame is truncated at MAX_LEN.

Function
REQ-014 States: IDLE, SEND, DROP, GAP, held in registers.
REQ-015 Source N requests when srcN_empty = 0 and srcN_dout[8] = 1.
REQ-016 IDLE:
- Any source whose head has bit 8 = 0 is popped and discarded: rd_en = 1, wr_en = 0.
- Both sources may be popped in the same cycle.
REQ-017 IDLE with one requester:
- Grant it.
- Next state SEND.
- No data moves in the grant cycle.
REQ-018 IDLE with two requesters: grant the source not served last (round robin); after reset, source 0 wins the first tie.
REQ-019 SEND transfer condition: owner not empty and full = 0. On transfer:
- owner rd_en = 1;
- wr_en = 1;
- din = owner dout, combinational, zero latency.
REQ-020 When a transfer is not possible in SEND: rd_en = 0 and wr_en = 0, and the state holds (stall, with no timeout).
REQ-021 Transferring a bit 8 = 0 word ends the frame:
- next state GAP (macro on) or IDLE (macro off);
- grant clears to 2'b00;
- the last-served pointer updates.
REQ-022 A 12-bit length counter:
- clears on entry to SEND;
- increments per bit 8 = 1 word transferred.
REQ-023 When the length counter equals MAX_LEN and the owner head has bit 8 = 1, with full = 0:
- write din = 9'h000 without popping the source;
- pulse err_len;
- next state DROP.
REQ-024 DROP:
- pop the owner whenever it is not empty;
- wr_en = 0;
- consuming a bit 8 = 0 word goes to GAP or IDLE as in REQ-021.
REQ-025 GAP:
- write din = 9'h000 each cycle that full = 0;
- count the writes;
- after IDLE_WORDS = IFG_WORDS writes, go to IDLE;
- full stalls the count.
REQ-026 A source that is not granted is never popped outside IDLE.
REQ-027 wr_en is never asserted while full = 1.
REQ-028 rd_en is never asserted while the corresponding empty = 1.

Reset
REQ-029 While sys_rst = 1:
- state = IDLE;
- grant = 2'b00;
- counters = 0;
- last-served pointer selects source 1, so source 0 wins the first tie;
- err_len = 0;
- src0_rd_en = src1_rd_en = wr_en = 0;
- din = 9'h000.
REQ-030 Reset during SEND, DROP or GAP abandons the frame with no terminator written; on the first cycle after reset, arbitration restarts in IDLE.

Configuration
REQ-031 Macro TXARB_IFG_EN.
- Defined: GAP state and IFG_WORDS apply as in REQ-025.
- Undefined: GAP is not built; frame end and DROP exit go directly to IDLE, and no gap words are written.

Verification
REQ-032 Single frame:
- Stimulus: src0 holds 60 words with bit 8 = 1 then 9'h000, full = 0.
- Response: 61 writes matching the source, then 12 writes of 9'h000 (macro on); grant = 2'b01 throughout the frame.
REQ-033 Contention:
- Stimulus: both sources hold 2 frames of 64 words, asserted in the same cycle after reset.
- Response: frame order 0,1,0,1; frames are never interleaved.
REQ-034 Backpressure:
- Stimulus: full toggles every other cycle during a 100-word frame.
- Response: no wr_en while full = 1; output is byte-exact; GAP still writes exactly 12 words.
REQ-035 Truncation:
- Stimulus: MAX_LEN = 64; src1 sends 80 words with bit 8 = 1 then 9'h000.
- Response: 64 data words, then 9'h000, then one err_len pulse; the remaining 16 words and the terminator are dropped; then GAP.
REQ-036 Stray marker and reset:
- Stimulus: src0 head is 9'h0AB in IDLE.
- Response: popped, nothing written.
- Stimulus: sys_rst asserted mid-frame.
- Response: next cycle all strobes are 0 and grant = 2'b00.
